br_ckpt_ctrl: RTL and testbench

Branch checkpoint controller for the physical-register free list. On each dispatched branch it snapshots the free-list head pointer (with wrap bit) and returns a branch tag. On branch resolution it releases the checkpoint, or, on mispredict, sequences a one-cycle recovery. During recovery it drives branch_state/rc_head to the free list and emits a squash mask of younger tags. It sits between decode/dispatch, the branch unit/ROB and the free list.

---
 rtl/br_ckpt_ctrl_pkg.sv | 39 +++
 rtl/br_squash_mask.sv | 41 ++++
 rtl/br_ckpt_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_br_ckpt_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_ckpt_ctrl_pkg.sv
// Shared definitions for the branch checkpoint controller.
// Carries the free-list handshake encodings (common with the free list) as
// macros, plus the enums and helpers used inside the controller.
// Optional feature macro: BR_CKPT_STATS_EN (adds resolve/mispredict counters).
`ifndef BR_CKPT_CTRL_DEFINES
`define BR_CKPT_CTRL_DEFINES
`define BR_STATE_W    2
`define BR_NO_BRANCH  2'd0
`define BR_PR_CORRECT 2'd1
`define BR_PR_WRONG   2'd2
`define FL_PTR_W      5
`define BR_DEPTH      4
`endif

package br_ckpt_ctrl_pkg;

  typedef enum logic {
    ST_NORMAL,
    ST_RECOVER
  } ckpt_state_e;

  typedef enum logic [`BR_STATE_W-1:0] {
    FL_NO_BRANCH  = `BR_NO_BRANCH,
    FL_PR_CORRECT = `BR_PR_CORRECT,
    FL_PR_WRONG   = `BR_PR_WRONG
  } fl_br_state_e;

  localparam int unsigned STAT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    if (en && (v != '1)) begin
      return v + STAT_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/br_squash_mask.sv
// Circular-range mask generator.
// Produces a one-bit-per-tag mask covering the half-open circular range
// [start, end) where both ends are tag indices with a wrap bit. Equal
// indices mean empty range (same wrap) or the whole ring (wrap differs).
// Ports:
//   start_idx_i / start_wrap_i : first tag of the range
//   end_idx_i   / end_wrap_i   : one past the last tag of the range
//   mask_o                     : BR_DEPTH-bit membership mask
module br_squash_mask
  import br_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned BR_DEPTH = `BR_DEPTH,
  parameter int unsigned BR_TAG_W = 2
) (
  input  logic [BR_TAG_W-1:0] start_idx_i,
  input  logic                start_wrap_i,
  input  logic [BR_TAG_W-1:0] end_idx_i,
  input  logic                end_wrap_i,
  output logic [BR_DEPTH-1:0] mask_o
);

  logic [BR_TAG_W-1:0] idx;

  always_comb begin
    mask_o = '0;
    idx    = '0;
    if (start_idx_i == end_idx_i) begin
      mask_o = (start_wrap_i != end_wrap_i) ? '1 : '0;
    end else begin
      for (int unsigned i = 0; i < BR_DEPTH; i++) begin
        idx = i[BR_TAG_W-1:0];
        if (start_idx_i < end_idx_i) begin
          mask_o[i] = (idx >= start_idx_i) && (idx < end_idx_i);
        end else begin
          mask_o[i] = (idx >= start_idx_i) || (idx < end_idx_i);
        end
      end
    end
  end

endmodule

// File: rtl/br_ckpt_ctrl.sv
// Branch checkpoint controller for the physical-register free list.
// Snapshots the free-list head on every accepted branch dispatch and hands
// back a tag; on resolution it releases the checkpoint in order, or on a
// mispredict runs a one-cycle recovery that restores the free-list head and
// squashes every younger tag.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   br_dispatch_i, fl_head_i : checkpoint request and head to snapshot
//   br_ckpt_ok_o, br_tag_o   : dispatch allowed / tag granted (combinational)
//   br_resolve_i, br_resolve_tag_i, br_mispredict_i : resolution from the branch unit
//   fl_branch_state_o, fl_rc_head_o : registered recovery handshake to the free list
//   squash_mask_o            : registered mask of killed tags during recovery
//   br_cnt_o                 : outstanding checkpoint count (0..BR_DEPTH)
//   stat_resolve_cnt_o, stat_mispred_cnt_o : only with BR_CKPT_STATS_EN
// Optional feature macro: BR_CKPT_STATS_EN.
module br_ckpt_ctrl
  import br_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned BR_DEPTH = `BR_DEPTH,
  parameter int unsigned FL_PTR_W = `FL_PTR_W,
  parameter int unsigned BR_TAG_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br_dispatch_i,
  input  logic [FL_PTR_W:0]      fl_head_i,
  output logic                   br_ckpt_ok_o,
  output logic [BR_TAG_W-1:0]    br_tag_o,
  input  logic                   br_resolve_i,
  input  logic [BR_TAG_W-1:0]    br_resolve_tag_i,
  input  logic                   br_mispredict_i,
  output logic [`BR_STATE_W-1:0] fl_branch_state_o,
  output logic [FL_PTR_W:0]      fl_rc_head_o,
  output logic [BR_DEPTH-1:0]    squash_mask_o,
`ifdef BR_CKPT_STATS_EN
  output logic [15:0]            stat_resolve_cnt_o,
  output logic [15:0]            stat_mispred_cnt_o,
`endif
  output logic [BR_TAG_W:0]      br_cnt_o
);

  localparam logic [BR_TAG_W:0] PTR_ONE = 1;

  logic [FL_PTR_W:0]   ckpt_q [BR_DEPTH];
  logic [FL_PTR_W:0]   ckpt_d [BR_DEPTH];
  logic [BR_DEPTH-1:0] vld_q, vld_d;
  logic [BR_TAG_W:0]   head_q, head_d;
  logic [BR_TAG_W:0]   tail_q, tail_d;
  ckpt_state_e         state_q, state_d;
  fl_br_state_e        fl_state_q, fl_state_d;
  logic [FL_PTR_W:0]   rc_head_q, rc_head_d;
  logic [BR_DEPTH-1:0] mask_q, mask_d;

  logic [BR_TAG_W-1:0] head_idx, tail_idx;
  logic                head_wrap, tail_wrap;
  logic                full, empty;
  logic                mp_req, res_hit, cr_acc, mp_acc, alloc;
  logic                tag_wrap;
  logic [BR_DEPTH-1:0] squash_range;
  logic [BR_DEPTH-1:0] live_mask;

  assign head_idx  = head_q[BR_TAG_W-1:0];
  assign head_wrap = head_q[BR_TAG_W];
  assign tail_idx  = tail_q[BR_TAG_W-1:0];
  assign tail_wrap = tail_q[BR_TAG_W];

  assign full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);
  assign empty = (head_q == tail_q);

  // The resolving tag carries no wrap bit; a tag below the tail index sits in
  // the tail's lap, anything at or above it belongs to the previous lap.
  assign tag_wrap = (br_resolve_tag_i < tail_idx) ? tail_wrap : ~tail_wrap;

  // Tags younger than (and including) the mispredicted one.
  br_squash_mask #(
    .BR_DEPTH (BR_DEPTH),
    .BR_TAG_W (BR_TAG_W)
  ) u_squash_range (
    .start_idx_i  (br_resolve_tag_i),
    .start_wrap_i (tag_wrap),
    .end_idx_i    (tail_idx),
    .end_wrap_i   (tail_wrap),
    .mask_o       (squash_range)
  );

  // Unsquashed window [head, tail); during recovery the tail already points
  // at the pending tag, so membership here means "older than pending".
  br_squash_mask #(
    .BR_DEPTH (BR_DEPTH),
    .BR_TAG_W (BR_TAG_W)
  ) u_live_range (
    .start_idx_i  (head_idx),
    .start_wrap_i (head_wrap),
    .end_idx_i    (tail_idx),
    .end_wrap_i   (tail_wrap),
    .mask_o       (live_mask)
  );

  always_comb begin
    mp_req       = br_resolve_i & br_mispredict_i;
    br_ckpt_ok_o = ~full & ~mp_req & (state_q == ST_NORMAL);
    br_tag_o     = tail_idx;
    alloc        = br_dispatch_i & br_ckpt_ok_o;
    res_hit      = br_resolve_i & vld_q[br_resolve_tag_i];
    cr_acc       = res_hit & ~br_mispredict_i;
    mp_acc       = res_hit & br_mispredict_i &
                   ((state_q == ST_NORMAL) | live_mask[br_resolve_tag_i]);
  end

  always_comb begin
    ckpt_d = ckpt_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;

    if (alloc) begin
      ckpt_d[tail_idx] = fl_head_i;
      vld_d[tail_idx]  = 1'b1;
      tail_d           = tail_q + PTR_ONE;
    end

    if (cr_acc) begin
      vld_d[br_resolve_tag_i] = 1'b0;
    end

    // Alloc is blocked whenever a mispredict is presented, so this never
    // competes with the allocation above.
    if (mp_acc) begin
      vld_d  = vld_q & ~squash_range;
      tail_d = {tag_wrap, br_resolve_tag_i};
    end

    if (!empty && !vld_q[head_idx]) begin
      head_d = head_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d    = mp_acc ? ST_RECOVER : ST_NORMAL;
    fl_state_d = FL_NO_BRANCH;
    rc_head_d  = rc_head_q;
    mask_d     = '0;
    if (mp_acc) begin
      fl_state_d = FL_PR_WRONG;
      rc_head_d  = ckpt_q[br_resolve_tag_i];
      mask_d     = squash_range;
    end else if (cr_acc) begin
      fl_state_d = FL_PR_CORRECT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ckpt_q     <= '{default: '0};
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      state_q    <= ST_NORMAL;
      fl_state_q <= FL_NO_BRANCH;
      rc_head_q  <= '0;
      mask_q     <= '0;
    end else begin
      ckpt_q     <= ckpt_d;
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      state_q    <= state_d;
      fl_state_q <= fl_state_d;
      rc_head_q  <= rc_head_d;
      mask_q     <= mask_d;
    end
  end

  assign fl_branch_state_o = fl_state_q;
  assign fl_rc_head_o      = rc_head_q;
  assign squash_mask_o     = mask_q;
  assign br_cnt_o          = tail_q - head_q;

`ifdef BR_CKPT_STATS_EN
  logic [STAT_W-1:0] stat_res_q, stat_res_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_res_d = sat_inc(stat_res_q, cr_acc | mp_acc);
    stat_mp_d  = sat_inc(stat_mp_q, mp_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_res_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  assign stat_resolve_cnt_o = stat_res_q;
  assign stat_mispred_cnt_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_br_ckpt_ctrl.sv
module tb_br_ckpt_ctrl;

  localparam int S_OK    = 0;
  localparam int S_TAG   = 1;
  localparam int S_STATE = 2;
  localparam int S_RC    = 3;
  localparam int S_MASK  = 4;
  localparam int S_CNT   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       br_dispatch_i;
  logic [5:0] fl_head_i;
  logic       br_ckpt_ok_o;
  logic [1:0] br_tag_o;
  logic       br_resolve_i;
  logic [1:0] br_resolve_tag_i;
  logic       br_mispredict_i;
  logic [1:0] fl_branch_state_o;
  logic [5:0] fl_rc_head_o;
  logic [3:0] squash_mask_o;
  logic [2:0] br_cnt_o;

  br_ckpt_ctrl #(
    .BR_DEPTH (4),
    .FL_PTR_W (5),
    .BR_TAG_W (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .br_dispatch_i     (br_dispatch_i),
    .fl_head_i         (fl_head_i),
    .br_ckpt_ok_o      (br_ckpt_ok_o),
    .br_tag_o          (br_tag_o),
    .br_resolve_i      (br_resolve_i),
    .br_resolve_tag_i  (br_resolve_tag_i),
    .br_mispredict_i   (br_mispredict_i),
    .fl_branch_state_o (fl_branch_state_o),
    .fl_rc_head_o      (fl_rc_head_o),
    .squash_mask_o     (squash_mask_o),
    .br_cnt_o          (br_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          when;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event mid_sample;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_OK:    return 32'(br_ckpt_ok_o);
      S_TAG:   return 32'(br_tag_o);
      S_STATE: return 32'(fl_branch_state_o);
      S_RC:    return 32'(fl_rc_head_o);
      S_MASK:  return 32'(squash_mask_o);
      default: return 32'(br_cnt_o);
    endcase
  endfunction

  // Monitor: pops every expectation due in the current cycle.
  int mi;
  initial forever begin
    @(negedge clk or mid_sample);
    mi = 0;
    while (mi < q.size()) begin
      if (q[mi].when == cyc) begin
        checks++;
        if (get_sig(q[mi].sel) !== q[mi].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                   q[mi].name, cyc, get_sig(q[mi].sel), q[mi].val);
        end
        q.delete(mi);
      end else if (q[mi].when < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cyc %0d never sampled", q[mi].name, q[mi].when);
        q.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic expect_at(input int dly, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.when = cyc + dly;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic drive(input logic d, input logic [5:0] h, input logic r,
                       input logic [1:0] t, input logic m);
    br_dispatch_i    = d;
    fl_head_i        = h;
    br_resolve_i     = r;
    br_resolve_tag_i = t;
    br_mispredict_i  = m;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    drive(1'b0, 6'h00, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 6'h00, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    expect_at(0, S_STATE, 0, "reset_state");
    expect_at(0, S_RC,    0, "reset_rc_head");
    expect_at(0, S_MASK,  0, "reset_mask");
    expect_at(0, S_CNT,   0, "reset_cnt");
    rst = 1'b1;
    adv();

    // Three dispatches: tags 0,1,2
    drive(1'b1, 6'h03, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_OK,  1, "t1_ok0");
    expect_at(0, S_TAG, 0, "t1_tag0");
    adv();
    drive(1'b1, 6'h07, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 1, "t1_tag1");
    adv();
    drive(1'b1, 6'h0A, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 2, "t1_tag2");
    adv();
    expect_at(0, S_CNT,   3, "t1_cnt3");
    expect_at(0, S_STATE, 0, "t1_state_idle");

    // Mispredict tag 1
    drive(1'b0, 6'h00, 1'b1, 2'd1, 1'b1);
    expect_at(0, S_OK,    0,      "t3_ok_blocked");
    expect_at(1, S_STATE, 2,      "t3_state_wrong");
    expect_at(1, S_RC,    6'h07,  "t3_rc_head");
    expect_at(1, S_MASK,  4'b0110, "t3_mask");
    expect_at(1, S_CNT,   1,      "t3_cnt");
    adv();
    expect_at(0, S_OK,    0, "t3_ok_in_recover");
    expect_at(1, S_STATE, 0, "t3_state_back");
    expect_at(1, S_MASK,  0, "t3_mask_clear");
    expect_at(1, S_OK,    1, "t3_ok_back");
    adv();

    // Refill tags 1,2 then resolve out of order
    drive(1'b1, 6'h11, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 1, "t4_tag1");
    adv();
    drive(1'b1, 6'h12, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 2, "t4_tag2");
    adv();
    drive(1'b0, 6'h00, 1'b1, 2'd1, 1'b0);
    expect_at(1, S_STATE, 1, "t4_correct1");
    expect_at(1, S_CNT,   3, "t4_head_held");
    adv();
    adv();
    drive(1'b0, 6'h00, 1'b1, 2'd0, 1'b0);
    expect_at(0, S_CNT,   3, "t4_cnt_pre");
    expect_at(1, S_STATE, 1, "t4_correct0");
    expect_at(1, S_CNT,   3, "t4_cnt_d1");
    expect_at(2, S_CNT,   2, "t4_head1");
    expect_at(2, S_STATE, 0, "t4_state_idle");
    expect_at(3, S_CNT,   1, "t4_head2");
    adv();
    adv();
    adv();

    // Fill to BR_DEPTH, then a rejected fifth dispatch
    drive(1'b1, 6'h13, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 3, "t2_tag3");
    adv();
    drive(1'b1, 6'h14, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 0, "t2_tag0_wrap");
    adv();
    drive(1'b1, 6'h15, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_TAG, 1, "t2_tag1");
    adv();
    drive(1'b1, 6'h3F, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_OK,  0, "t2_full_ok");
    expect_at(0, S_TAG, 2, "t2_full_tag");
    expect_at(1, S_CNT, 4, "t2_full_cnt");
    adv();
    drive(1'b0, 6'h00, 1'b1, 2'd2, 1'b0);
    expect_at(0, S_OK,    0, "t2_ok_still_full");
    expect_at(1, S_STATE, 1, "t2_correct");
    expect_at(1, S_CNT,   4, "t2_cnt_d1");
    expect_at(2, S_CNT,   3, "t2_head_adv");
    expect_at(2, S_OK,    1, "t2_ok_back");
    adv();
    adv();
    adv();

    // Mispredict youngest (tag 1), then older tag 0 during recovery
    drive(1'b0, 6'h00, 1'b1, 2'd1, 1'b1);
    expect_at(0, S_OK,    0,       "t5_ok0");
    expect_at(1, S_STATE, 2,       "t5_wrong1");
    expect_at(1, S_RC,    6'h15,   "t5_rc1");
    expect_at(1, S_MASK,  4'b0010, "t5_mask1");
    expect_at(1, S_CNT,   2,       "t5_cnt1");
    adv();
    drive(1'b0, 6'h00, 1'b1, 2'd0, 1'b1);
    expect_at(0, S_OK,    0,       "t5_ok_recover");
    expect_at(1, S_STATE, 2,       "t5_wrong2");
    expect_at(1, S_RC,    6'h14,   "t5_rc2");
    expect_at(1, S_MASK,  4'b0001, "t5_mask2");
    expect_at(1, S_CNT,   1,       "t5_cnt2");
    adv();

    // Asynchronous reset in the middle of recovery
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    expect_at(0, S_STATE, 0, "t6_async_state");
    expect_at(0, S_RC,    0, "t6_async_rc");
    expect_at(0, S_MASK,  0, "t6_async_mask");
    expect_at(0, S_CNT,   0, "t6_async_cnt");
    expect_at(0, S_OK,    1, "t6_async_ok");
    -> mid_sample;
    adv();
    rst = 1'b1;
    expect_at(0, S_CNT,   0, "t6_cnt_after");
    expect_at(0, S_TAG,   0, "t6_tag_after");

    // Resolve of an unallocated tag is ignored
    drive(1'b0, 6'h00, 1'b1, 2'd3, 1'b0);
    expect_at(1, S_STATE, 0, "inv_resolve_ignored");
    adv();
    drive(1'b1, 6'h3F, 1'b0, 2'd0, 1'b0);
    expect_at(0, S_OK,  1, "post_ok");
    expect_at(0, S_TAG, 0, "post_tag");
    adv();
    drive(1'b0, 6'h00, 1'b1, 2'd0, 1'b1);
    expect_at(1, S_STATE, 2,       "post_wrong");
    expect_at(1, S_RC,    6'h3F,   "post_rc_full_width");
    expect_at(1, S_MASK,  4'b0001, "post_mask");
    expect_at(1, S_CNT,   0,       "post_cnt");
    adv();
    adv();
    adv();

    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL pending: %0d expectations never sampled, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
